// File: rtl/encoder_16x4_stream_pkg.sv
// encoder_pkg: shared sizes, vector/index/count types, FSM states and popcount for the 16x4 stream encoder.
package encoder_pkg;
   localparam int N = 16;
   localparam int W = $clog2(N);
   typedef logic [N-1:0] req_vec_t;
   typedef logic [W-1:0] idx_t;
   typedef logic [W:0]   cnt_t;
   typedef enum logic {IDLE, EMIT} state_t;
   function automatic cnt_t popcount(input req_vec_t v);
      cnt_t c;
      c = '0;
      for (int i = 0; i < N; i++) c = c + cnt_t'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/encoder_16x4_stream_prio.sv
// priority_encoder_16x4: first set bit of vec at or after start, wrapping modulo N.
module priority_encoder_16x4 import encoder_pkg::*; (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] index
);
   logic [2*N-1:0] dbl;
   req_vec_t       rot;
   idx_t           off;
   // Rotating right by start turns the wrapped search into a plain lowest-bit search.
   always_comb begin
      dbl = {vec, vec} >> start;
      rot = dbl[N-1:0];
      off = '0;
      for (int i = N - 1; i >= 0; i--) off = rot[i] ? idx_t'(i) : off;
      found = |vec;
      index = off + start;
   end
endmodule

// File: rtl/encoder_16x4_stream.sv
// encoder_16x4_stream: merges request vectors into a pending set and streams binary indices over valid/ready.
// Define ROUND_ROBIN_EN for rotating priority; otherwise lowest index always wins.
module encoder_16x4_stream import encoder_pkg::*; (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [N-1:0] load_vec,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_index,
   output logic [W:0]   pend_cnt,
   output logic         busy
);
   state_t   state, state_nxt;
   req_vec_t pending, cand, pend_nxt;
   idx_t     sel, start, idx_nxt;
   logic     found, free, grant;

`ifdef ROUND_ROBIN_EN
   idx_t last_granted;
   assign start = last_granted + idx_t'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last_granted <= idx_t'(N - 1);
      else if (grant) last_granted <= sel;
`else
   assign start = '0;
`endif

   priority_encoder_16x4 u_prio (
      .vec   (cand),
      .start (start),
      .found (found),
      .index (sel)
   );

   // Held index is excluded from pending, so a reload of it queues a fresh emission.
   always_comb begin
      cand      = pending | (load ? load_vec : '0);
      free      = (state == IDLE) | out_ready;
      grant     = !flush & free & found;
      pend_nxt  = flush ? '0 : grant ? cand & ~(req_vec_t'(1) << sel) : cand;
      idx_nxt   = flush ? '0 : grant ? sel : out_index;
      state_nxt = (flush | (free & !found)) ? IDLE : grant ? EMIT : state;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         out_index <= '0;
         pend_cnt  <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         pending   <= pend_nxt;
         out_index <= idx_nxt;
         pend_cnt  <= popcount(pend_nxt);
         busy      <= (state_nxt == EMIT) | (|pend_nxt);
      end

   assign out_valid = (state == EMIT);
endmodule

// File: tb/tb_encoder_16x4_stream.sv
// tb_encoder_16x4_stream: directed and random stimulus checked against a bit-set reference model.
module tb_encoder_16x4_stream;
   logic        clk = 0;
   logic        rst_n = 0;
   logic        load = 0;
   logic [15:0] load_vec = '0;
   logic        flush = 0;
   logic        out_valid;
   logic        out_ready = 0;
   logic [3:0]  out_index;
   logic [4:0]  pend_cnt;
   logic        busy;

   int n_assert = 0;
   int n_fail = 0;

   logic [15:0] m_pend;
   logic        m_valid;
   logic [3:0]  m_idx;
   int          m_last;
`ifdef ROUND_ROBIN_EN
   localparam bit RR = 1;
`else
   localparam bit RR = 0;
`endif

   encoder_16x4_stream dut (
      .clk(clk), .rst_n(rst_n), .load(load), .load_vec(load_vec), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
      .pend_cnt(pend_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_valid = 0; m_idx = '0; m_last = 15;
   endtask

   task automatic model_step(input logic l, input logic [15:0] v, input logic r, input logic f);
      logic [15:0] c;
      int start, sel;
      if (f) begin
         m_pend = '0; m_valid = 0; m_idx = '0;
         return;
      end
      c = m_pend | (l ? v : 16'h0);
      if (!m_valid || r) begin
         start = RR ? (m_last + 1) % 16 : 0;
         sel = -1;
         for (int k = 0; k < 16; k++)
            if (sel < 0 && c[(start + k) % 16]) sel = (start + k) % 16;
         if (sel >= 0) begin
            m_valid = 1; m_idx = 4'(sel); m_last = sel; c[sel] = 1'b0;
         end else m_valid = 0;
      end
      m_pend = c;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
      if (m_valid) chk({tag, ".index"}, 32'(out_index), 32'(m_idx));
      chk({tag, ".pend_cnt"}, 32'(pend_cnt), 32'($countones(m_pend)));
      chk({tag, ".busy"}, 32'(busy), 32'(m_valid || m_pend != 0));
   endtask

   task automatic cyc(input logic l, input logic [15:0] v, input logic r, input logic f, input string tag);
      load = l; load_vec = v; out_ready = r; flush = f;
      @(posedge clk);
      model_step(l, v, r, f);
      #1;
      check_model(tag);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset.valid", 32'(out_valid), 0);
      chk("reset.index", 32'(out_index), 0);
      chk("reset.cnt", 32'(pend_cnt), 0);
      chk("reset.busy", 32'(busy), 0);
      #2 rst_n = 1;

      // lowest-first streaming with one-cycle latency
      cyc(1, 16'h8421, 1, 0, "t1");
      chk("t1.first", 32'(out_index), 0);
      cyc(0, 0, 1, 0, "t1"); chk("t1.second", 32'(out_index), 5);
      cyc(0, 0, 1, 0, "t1"); chk("t1.third", 32'(out_index), 10);
      cyc(0, 0, 1, 0, "t1"); chk("t1.fourth", 32'(out_index), 15);
      cyc(0, 0, 1, 0, "t1"); chk("t1.drain_valid", 32'(out_valid), 0);
      chk("t1.drain_busy", 32'(busy), 0);

      // stall holds index
      cyc(1, 16'h0006, 0, 0, "t2");
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0, "t2");
         chk("t2.stall_idx", 32'(out_index), 1);
         chk("t2.stall_cnt", 32'(pend_cnt), 1);
      end
      cyc(0, 0, 1, 0, "t2"); chk("t2.next", 32'(out_index), 2);
      cyc(0, 0, 1, 0, "t2");

      // reloading the held index re-queues it
      cyc(1, 16'h0008, 0, 0, "t3"); chk("t3.first", 32'(out_index), 3);
      cyc(1, 16'h0008, 0, 0, "t3"); chk("t3.requeued_cnt", 32'(pend_cnt), 1);
      cyc(0, 0, 1, 0, "t3"); chk("t3.again", 32'(out_index), 3);
      chk("t3.again_valid", 32'(out_valid), 1);
      cyc(0, 0, 1, 0, "t3");

      // flush beats load and handshake
      cyc(1, 16'hFFFF, 1, 0, "t4");
      cyc(0, 0, 1, 0, "t4");
      cyc(0, 0, 1, 0, "t4");
      cyc(1, 16'hFFFF, 1, 1, "t4");
      chk("t4.flush_valid", 32'(out_valid), 0);
      chk("t4.flush_cnt", 32'(pend_cnt), 0);

      // grant 4, then stall while loading 0x13
      cyc(1, 16'h0010, 1, 0, "t5"); chk("t5.grant4", 32'(out_index), 4);
      cyc(1, 16'h0013, 0, 0, "t5"); chk("t5.held4", 32'(out_index), 4);
      cyc(0, 0, 1, 0, "t5"); chk("t5.a", 32'(out_index), 0);
      cyc(0, 0, 1, 0, "t5"); chk("t5.b", 32'(out_index), 1);
      cyc(0, 0, 1, 0, "t5"); chk("t5.c", 32'(out_index), 4);
      cyc(0, 0, 1, 0, "t5");

      // random traffic
      for (int i = 0; i < 400; i++)
         cyc(($urandom % 3) == 0, 16'($urandom & $urandom), ($urandom % 4) != 0,
             ($urandom % 25) == 0, "rand");

      // asynchronous reset mid-stream
      cyc(1, 16'hF0F0, 1, 0, "t7");
      cyc(0, 0, 0, 0, "t7");
      #2 rst_n = 0;
      #1;
      chk("arst.valid", 32'(out_valid), 0);
      chk("arst.index", 32'(out_index), 0);
      chk("arst.cnt", 32'(pend_cnt), 0);
      chk("arst.busy", 32'(busy), 0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1;
      cyc(1, 16'h0300, 1, 0, "t7");
      chk("t7.after", 32'(out_index), 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
